ov7670_config_sequencer: RTL

Walks a register-initialisation table and issues one SCCB 3-phase write per entry through the SCCB master's host interface. It sits between top-level bring-up logic and the SCCB master, so the master never needs manual sequencing. The table lives in an external synchronous ROM (1-cycle read latency). Table entries are 16 bits, {subaddress[15:8], data[7:0]}, with two reserved codes: 16'hFFFF ends the table and 16'hFFF0 inserts a delay.

---
 rtl/ov7670_config_sequencer_if.sv | 30 +++
 rtl/ov7670_config_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_config_sequencer_if.sv
// Host-side bus between the OV7670 configuration sequencer and the SCCB master.
interface ov7670_config_sequencer_if;
  logic        o_usher;
  logic [7:0]  o_address;
  logic [7:0]  o_subaddress;
  logic [7:0]  o_data;
  logic [1:0]  o_mode;
  logic [15:0] o_prescaler;
  logic        i_sccb_busy;

  modport master (
    output o_usher,
    output o_address,
    output o_subaddress,
    output o_data,
    output o_mode,
    output o_prescaler,
    input  i_sccb_busy
  );

  modport slave (
    input  o_usher,
    input  o_address,
    input  o_subaddress,
    input  o_data,
    input  o_mode,
    input  o_prescaler,
    output i_sccb_busy
  );
endinterface

// File: rtl/ov7670_config_sequencer.sv
// Walks an external init ROM and issues one SCCB 3-phase write per entry.
// Optional: define SEQ_TIMEOUT_EN to add a watchdog on the SCCB busy handshake.
module ov7670_config_sequencer #(
  parameter logic [7:0]  SLAVE_ADDR     = 8'h42,
  parameter logic [15:0] PRESCALER      = 16'd125,
  parameter int unsigned ROM_AW         = 8,
  parameter int unsigned POWERUP_CYCLES = 100000,
  parameter int unsigned DELAY_CYCLES   = 1000000,
  parameter int unsigned GAP_CYCLES     = 250,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_error,
  output logic [ROM_AW-1:0]         o_rom_addr,
  input  logic [15:0]               i_rom_data,
  output logic [ROM_AW:0]           o_write_count,
  ov7670_config_sequencer_if.master sccb
);

  localparam logic [15:0] ENTRY_END = 16'hFFFF;
  localparam logic [15:0] ENTRY_DLY = 16'hFFF0;

  // One shared down-time counter, sized for the longest wait it has to cover.
  localparam int unsigned MAX_AB  = (POWERUP_CYCLES > DELAY_CYCLES) ? POWERUP_CYCLES : DELAY_CYCLES;
  localparam int unsigned MAX_CD  = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam int unsigned WC_W    = ROM_AW + 1;

  localparam logic [CNT_W-1:0]  PWR_LAST  = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DLY_LAST  = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
`ifdef SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
  localparam logic [ROM_AW-1:0] ADDR_LAST = '1;
  localparam logic [ROM_AW:0]   WC_MAX    = {1'b1, {ROM_AW{1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE, S_POWERUP, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_HI,
    S_WAIT_LO, S_GAP, S_DELAY, S_DONE, S_ERROR
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [ROM_AW-1:0]   r_rom_addr, w_rom_addr_nxt;
  logic [7:0]          r_sub, w_sub_nxt;
  logic [7:0]          r_data, w_data_nxt;
  logic [ROM_AW:0]     r_wcount, w_wcount_nxt;
  logic                r_usher, w_usher_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_error, w_error_nxt;
  logic                w_last_addr;

  assign w_last_addr = (r_rom_addr == ADDR_LAST);

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rom_addr <= '0;
      r_sub      <= '0;
      r_data     <= '0;
      r_wcount   <= '0;
      r_usher    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rom_addr <= w_rom_addr_nxt;
      r_sub      <= w_sub_nxt;
      r_data     <= w_data_nxt;
      r_wcount   <= w_wcount_nxt;
      r_usher    <= w_usher_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_error    <= w_error_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = '0;
    w_rom_addr_nxt = r_rom_addr;
    w_sub_nxt      = r_sub;
    w_data_nxt     = r_data;
    w_wcount_nxt   = r_wcount;
    w_usher_nxt    = 1'b0;
    w_error_nxt    = r_error;

    unique case (r_state)
      S_IDLE, S_ERROR: begin
        if (i_start) begin
          w_state_nxt    = S_POWERUP;
          w_rom_addr_nxt = '0;
          w_wcount_nxt   = '0;
          w_error_nxt    = 1'b0;
        end
      end
      S_POWERUP: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == PWR_LAST) w_state_nxt = S_FETCH;
      end
      S_FETCH: w_state_nxt = S_DECODE;
      S_DECODE: begin
        if (i_rom_data == ENTRY_END) begin
          w_state_nxt = S_DONE;
        end else if (i_rom_data == ENTRY_DLY) begin
          if (w_last_addr) begin
            w_state_nxt = S_ERROR;
            w_error_nxt = 1'b1;
          end else begin
            w_rom_addr_nxt = r_rom_addr + ROM_AW'(1);
            w_state_nxt    = S_DELAY;
          end
        end else begin
          w_sub_nxt   = i_rom_data[15:8];
          w_data_nxt  = i_rom_data[7:0];
          w_state_nxt = S_ISSUE;
        end
      end
      // Hold off the request while the master is still finishing something else.
      S_ISSUE: begin
        if (!sccb.i_sccb_busy) begin
          w_usher_nxt = 1'b1;
          w_state_nxt = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
`ifdef SEQ_TIMEOUT_EN
        w_cnt_nxt = r_cnt + CNT_W'(1);
`endif
        if (sccb.i_sccb_busy) begin
          w_state_nxt = S_WAIT_LO;
`ifdef SEQ_TIMEOUT_EN
        end else if (r_cnt == TO_LAST) begin
          w_state_nxt = S_ERROR;
          w_error_nxt = 1'b1;
`endif
        end
      end
      S_WAIT_LO: begin
`ifdef SEQ_TIMEOUT_EN
        w_cnt_nxt = r_cnt + CNT_W'(1);
`endif
        if (!sccb.i_sccb_busy) begin
          if (r_wcount != WC_MAX) w_wcount_nxt = r_wcount + WC_W'(1);
          if (w_last_addr) begin
            w_state_nxt = S_ERROR;
            w_error_nxt = 1'b1;
          end else begin
            w_rom_addr_nxt = r_rom_addr + ROM_AW'(1);
            w_state_nxt    = S_GAP;
          end
`ifdef SEQ_TIMEOUT_EN
        end else if (r_cnt == TO_LAST) begin
          w_state_nxt = S_ERROR;
          w_error_nxt = 1'b1;
`endif
        end
      end
      S_GAP: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == GAP_LAST) w_state_nxt = S_FETCH;
      end
      S_DELAY: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == DLY_LAST) w_state_nxt = S_FETCH;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Every wait starts counting from zero on entry.
    if (w_state_nxt != r_state) w_cnt_nxt = '0;

    w_busy_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_ERROR);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign o_error           = r_error;
  assign o_rom_addr        = r_rom_addr;
  assign o_write_count     = r_wcount;
  assign sccb.o_usher      = r_usher;
  assign sccb.o_address    = SLAVE_ADDR;
  assign sccb.o_subaddress = r_sub;
  assign sccb.o_data       = r_data;
  assign sccb.o_mode       = 2'b00;
  assign sccb.o_prescaler  = PRESCALER;

endmodule
